// File: rtl/hailstone_engine.sv
// Hailstone (Collatz) sequence engine: counts steps to reach 1 and tracks the peak value.
// Optional macro HAILSTONE_ODD_FUSE_EN fuses each odd step with the halving that follows it.
module hailstone_engine #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     n_in,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] steps,
    output logic [WIDTH-1:0]     peak,
    output logic                 overflow,
    output logic                 err_zero,
    output logic [1:0]           dbg_state
);

    // Handshake: start is a request sampled only in IDLE (busy=0, done=0); the
    // edge that sees it captures n_in. done is a one-cycle completion strobe, and
    // steps/peak/overflow/err_zero stay valid from then until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] STEPS_MAX = '1;

    state_t          state;
    logic [WIDTH-1:0] n;

    logic [WIDTH+1:0]     n3p1;
    logic                 n3_ovf;
    logic [CNT_WIDTH:0]   steps_p1;
    logic [CNT_WIDTH:0]   steps_p2;
    logic                 even_sat;
    logic                 odd_sat;
    logic [CNT_WIDTH-1:0] odd_steps;
    logic [WIDTH-1:0]     odd_n;
    logic [WIDTH-1:0]     n_half;

    // 3n+1 is formed two bits wider so a result >= 2^WIDTH is visible in the top bits.
    assign n3p1     = {2'b00, n} + {1'b0, n, 1'b0} + (WIDTH+2)'(1);
    assign n3_ovf   = |n3p1[WIDTH+1:WIDTH];
    assign steps_p1 = {1'b0, steps} + (CNT_WIDTH+1)'(1);
    assign steps_p2 = {1'b0, steps} + (CNT_WIDTH+1)'(2);
    assign even_sat = steps_p1[CNT_WIDTH];
    assign n_half   = n >> 1;

`ifdef HAILSTONE_ODD_FUSE_EN
    assign odd_sat   = steps_p2[CNT_WIDTH];
    assign odd_steps = steps_p2[CNT_WIDTH-1:0];
    assign odd_n     = {1'b0, n3p1[WIDTH-1:1]};
`else
    assign odd_sat   = steps_p1[CNT_WIDTH];
    assign odd_steps = steps_p1[CNT_WIDTH-1:0];
    assign odd_n     = n3p1[WIDTH-1:0];
`endif

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n        <= '0;
            steps    <= '0;
            peak     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            err_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        steps    <= '0;
                        overflow <= 1'b0;
                        if (n_in == '0) begin
                            n        <= '0;
                            peak     <= '0;
                            err_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            n        <= n_in;
                            peak     <= n_in;
                            err_zero <= 1'b0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (n == WIDTH'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (!n[0]) begin
                        // Halving never raises the value, so peak cannot change here.
                        if (even_sat) begin
                            steps    <= STEPS_MAX;
                            overflow <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            n     <= n_half;
                            steps <= steps_p1[CNT_WIDTH-1:0];
                        end
                    end else if (n3_ovf) begin
                        overflow <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (odd_sat) begin
                        steps    <= STEPS_MAX;
                        overflow <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        n     <= odd_n;
                        steps <= odd_steps;
                        if (n3p1[WIDTH-1:0] > peak) begin
                            peak <= n3p1[WIDTH-1:0];
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
